// File: rtl/int_sequencer.sv
// Prioritised interrupt sequencer: synchronises request pulses, latches them as pending and
// hands one request at a time to the CPU. Build option INT_NEST_EN enables nested preemption.
module int_sequencer #(
    parameter int                N_SRC      = 3,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 12'h100,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 12'h010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              en_we,
    input  logic [N_SRC-1:0]  en_wdata,
    input  logic              int_ack,
    input  logic              int_eret,
    output logic              int_req,
    output logic [ADDR_W-1:0] int_vec,
    output logic [1:0]        int_id,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  in_service
);

    // state | meaning
    // IDLE  | no request outstanding; arbitrate eligible pending sources
    // REQ   | int_req high, id/vec frozen until the CPU acks
    typedef enum logic {IDLE, REQ} state_t;

    state_t           state;
    logic [N_SRC-1:0] sync1, sync2, sync3;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] eret_mask;
    logic [1:0]       hi;
    logic [1:0]       winner;
    logic             active;
    logic             ack_take;

    assign rise     = sync2 & ~sync3;
    assign active   = |in_service;
    assign ack_take = (state == REQ) && int_ack;

    always_comb begin
        hi        = 2'd0;
        winner    = 2'd0;
        eligible  = '0;
        ack_mask  = '0;
        eret_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (in_service[i]) hi = 2'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
`ifdef INT_NEST_EN
            eligible[i] = pending[i] & enable[i] & (!active || (i > int'(hi)));
`else
            eligible[i] = pending[i] & enable[i] & !active;
`endif
            if (eligible[i]) winner = 2'(i);
            ack_mask[i]  = ack_take && (int_id == 2'(i));
            // without nesting in_service is one-hot, so dropping its top bit clears it
            eret_mask[i] = int_eret && active && (hi == 2'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
            enable     <= '1;
            pending    <= '0;
            in_service <= '0;
        end else begin
            sync1      <= irq_in;
            sync2      <= sync1;
            sync3      <= sync2;
            if (en_we) enable <= en_wdata;
            // a fresh edge on the acked source re-arms it
            pending    <= (pending & ~ack_mask) | rise;
            in_service <= (in_service & ~eret_mask) | ack_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= 2'd0;
            int_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= winner;
                        int_vec <= VEC_BASE + ADDR_W'(winner) * VEC_STRIDE;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: a vector table for the basic flows plus hand-written
// sequences for priority, freezing, coincident ack/edge and mid-request reset.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        en_we;
    logic [2:0]  en_wdata;
    logic        int_ack;
    logic        int_eret;
    logic        int_req;
    logic [11:0] int_vec;
    logic [1:0]  int_id;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int total = 0;
    int bad   = 0;

    int_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .en_we      (en_we),
        .en_wdata   (en_wdata),
        .int_ack    (int_ack),
        .int_eret   (int_eret),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  irq;
        logic        we;
        logic [2:0]  wdata;
        logic        ack;
        logic        eret;
        logic        exp_req;
        logic [1:0]  exp_id;
        logic [11:0] exp_vec;
        logic [2:0]  exp_pend;
        logic [2:0]  exp_isv;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string name, input logic [1:0] id, input logic [11:0] vec);
        check({name, ".req"}, 32'(int_req), 32'd1);
        check({name, ".id"},  32'(int_id),  32'(id));
        check({name, ".vec"}, 32'(int_vec), 32'(vec));
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        int_eret = 1'b1;
        step(1);
        int_eret = 1'b0;
    endtask

    initial begin
        //           irq     we  wdata   ack eret req id vec      pend    isv
        vecs[0]  = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[1]  = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[2]  = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b001, 3'b000};
        vecs[3]  = '{3'b001, 0, 3'b000, 0, 0, 1, 0, 12'h100, 3'b001, 3'b000};
        vecs[4]  = '{3'b001, 0, 3'b000, 1, 0, 0, 0, 12'h000, 3'b000, 3'b001};
        vecs[5]  = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b000, 3'b001};
        vecs[6]  = '{3'b000, 0, 3'b000, 0, 1, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[7]  = '{3'b000, 0, 3'b000, 1, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[8]  = '{3'b000, 1, 3'b110, 0, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[9]  = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[10] = '{3'b001, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b000, 3'b000};
        vecs[11] = '{3'b000, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b001, 3'b000};
        vecs[12] = '{3'b000, 0, 3'b000, 0, 0, 0, 0, 12'h000, 3'b001, 3'b000};
        vecs[13] = '{3'b000, 1, 3'b111, 0, 0, 0, 0, 12'h000, 3'b001, 3'b000};
        vecs[14] = '{3'b000, 0, 3'b000, 0, 0, 1, 0, 12'h100, 3'b001, 3'b000};
        vecs[15] = '{3'b000, 0, 3'b000, 1, 0, 0, 0, 12'h000, 3'b000, 3'b001};
        vecs[16] = '{3'b000, 0, 3'b000, 0, 1, 0, 0, 12'h000, 3'b000, 3'b000};

        rst = 1'b0; irq_in = '0; en_we = 1'b0; en_wdata = '0; int_ack = 1'b0; int_eret = 1'b0;
        step(2);
        check("rst.req",  32'(int_req),    32'd0);
        check("rst.vec",  32'(int_vec),    32'd0);
        check("rst.id",   32'(int_id),     32'd0);
        check("rst.pend", 32'(pending),    32'd0);
        check("rst.isv",  32'(in_service), 32'd0);
        rst = 1'b1;
        step(1);

        for (int i = 0; i < 17; i++) begin
            irq_in = vecs[i].irq; en_we = vecs[i].we; en_wdata = vecs[i].wdata;
            int_ack = vecs[i].ack; int_eret = vecs[i].eret;
            step(1);
            check($sformatf("v%0d.req", i),  32'(int_req),    32'(vecs[i].exp_req));
            check($sformatf("v%0d.pend", i), 32'(pending),    32'(vecs[i].exp_pend));
            check($sformatf("v%0d.isv", i),  32'(in_service), 32'(vecs[i].exp_isv));
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d.id", i),  32'(int_id),  32'(vecs[i].exp_id));
                check($sformatf("v%0d.vec", i), 32'(int_vec), 32'(vecs[i].exp_vec));
            end
        end
        irq_in = '0; en_we = 1'b0; int_ack = 1'b0; int_eret = 1'b0;

        // two sources in the same cycle: 2 first, 0 only after 2 returns
        irq_in = 3'b101;
        step(3);
        check("prio.pend", 32'(pending), 32'b101);
        irq_in = '0;
        step(1);
        check_req("prio.g2", 2'd2, 12'h120);
        pulse_ack();
        check("prio.ack.req",  32'(int_req),    32'd0);
        check("prio.ack.pend", 32'(pending),    32'b001);
        check("prio.ack.isv",  32'(in_service), 32'b100);
        step(2);
        check("prio.wait.req", 32'(int_req), 32'd0);
        pulse_eret();
        check("prio.eret.isv", 32'(in_service), 32'b000);
        check("prio.eret.req", 32'(int_req),    32'd0);
        step(1);
        check_req("prio.g0", 2'd0, 12'h100);
        pulse_ack();
        check("prio.g0.isv", 32'(in_service), 32'b001);
        pulse_eret();
        check("prio.g0.eret", 32'(in_service), 32'b000);

        // higher source arriving while REQ is outstanding must not change the grant
        irq_in = 3'b001;
        step(3);
        irq_in = '0;
        step(1);
        check_req("frz.g0", 2'd0, 12'h100);
        irq_in = 3'b100;
        step(3);
        irq_in = '0;
        step(1);
        check_req("frz.hold", 2'd0, 12'h100);
        check("frz.pend", 32'(pending), 32'b101);
        pulse_ack();
        check("frz.ack.pend", 32'(pending),    32'b100);
        check("frz.ack.isv",  32'(in_service), 32'b001);
        check("frz.ack.req",  32'(int_req),    32'd0);
        step(1);
`ifdef INT_NEST_EN
        check_req("frz.nest.g2", 2'd2, 12'h120);
        pulse_ack();
        check("frz.nest.isv2", 32'(in_service), 32'b101);
        pulse_eret();
        check("frz.nest.eret1", 32'(in_service), 32'b001);
        pulse_eret();
        check("frz.nest.eret2", 32'(in_service), 32'b000);
`else
        check("frz.blocked", 32'(int_req), 32'd0);
        pulse_eret();
        check("frz.eret.isv", 32'(in_service), 32'b000);
        check("frz.eret.req", 32'(int_req),    32'd0);
        step(1);
        check_req("frz.g2", 2'd2, 12'h120);
        pulse_ack();
        check("frz.g2.isv", 32'(in_service), 32'b100);
        pulse_eret();
        check("frz.g2.eret", 32'(in_service), 32'b000);
`endif

        // a new edge on source 1 detected in the same cycle it is acked
        irq_in = 3'b010;
        step(3);
        irq_in = '0;
        step(1);
        check_req("coin.g1", 2'd1, 12'h110);
        step(2);
        irq_in = 3'b010;
        step(2);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        irq_in = '0;
        check("coin.pend", 32'(pending),    32'b010);
        check("coin.isv",  32'(in_service), 32'b010);
        check("coin.req",  32'(int_req),    32'd0);
        pulse_eret();
        check("coin.eret", 32'(in_service), 32'b000);
        step(1);
        check_req("coin.regrant", 2'd1, 12'h110);

        // asynchronous reset in the middle of a request
        rst = 1'b0;
        #1;
        check("mrst.req",  32'(int_req),    32'd0);
        check("mrst.id",   32'(int_id),     32'd0);
        check("mrst.vec",  32'(int_vec),    32'd0);
        check("mrst.pend", 32'(pending),    32'd0);
        check("mrst.isv",  32'(in_service), 32'd0);
        step(1);
        rst = 1'b1;
        step(4);
        check("mrst.after.req",  32'(int_req), 32'd0);
        check("mrst.after.pend", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Prioritised interrupt controller that sequences the CPU's interrupt entry and return for the three external interrupt request lines (the `pro_reset` button pulses).
- Synchronises and edge-detects each request, latches it as pending, and arbitrates by fixed priority (source 2 highest, source 0 lowest).
- Presents one request plus entry vector to the CPU core and tracks in-service state across the CPU's ack and eret handshakes.
- Sits between the board inputs and the CPU top; `in_service` can drive the `leds` outputs directly.

Parameters:
- N_SRC, 3, number of interrupt sources (sized for 2..4; `int_id` is 2 bits).
- ADDR_W, 12, width of the entry vector (matches CPU instruction address width).
- VEC_BASE, 12'h100, entry address of source 0.
- VEC_STRIDE, 12'h010, address spacing between source vectors.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_in  in  N_SRC  raw asynchronous request pulses, level-high.
- en_we  in  1  write strobe for the enable register.
- en_wdata  in  N_SRC  new enable mask; 1 = source enabled.
- int_ack  in  1  one-cycle pulse from the CPU: request taken, ISR entered.
- int_eret  in  1  one-cycle pulse from the CPU: ISR returned.
- int_req  out  1  interrupt request to the CPU.
- int_vec  out  ADDR_W  entry address of the granted source: VEC_BASE + id*VEC_STRIDE.
- int_id  out  2  granted source index.
- pending  out  N_SRC  latched, not-yet-acknowledged requests.
- in_service  out  N_SRC  ISRs currently active.

Behaviour:
- Reset (rst=0, asynchronous): sync flops=0, pending=0, in_service=0, enable=all ones, FSM=IDLE, int_req=0, int_vec=0, int_id=0.
- Input path:
  - 2-flop synchroniser per source, then rising-edge detect against a third flop.
  - A rising edge sets pending[i] 3 cycles after the input edge.
  - A level held high sets pending only once.
- Enable register:
  - Written when en_we=1, effective next cycle.
  - A disabled source still latches pending; it is only excluded from arbitration.
- Eligibility:
  - eligible[i] = pending[i] & enable[i] & (i > highest set in_service index, or in_service==0).
  - The winner is the highest eligible index.
- FSM:
  - IDLE:
    - int_req=0.
    - If eligible≠0, latch int_id=winner and int_vec=VEC_BASE+winner*VEC_STRIDE, go to REQ; int_req=1 from the next cycle.
  - REQ:
    - int_req=1; int_id and int_vec are frozen, with no re-arbitration even if a higher source arrives or enable changes.
    - On int_ack: clear pending[int_id], set in_service[int_id], go to IDLE; int_req drops the next cycle.
    - Minimum spacing between two grants is 2 cycles.
  - int_ack outside REQ is ignored.
- Return:
  - int_eret clears the highest set in_service bit.
  - int_eret with in_service==0 is ignored.
  - int_eret is accepted in any FSM state.
- Simultaneous events:
  - New edge on source i in the same cycle as ack of i: pending[i] ends at 1 (new event wins); in_service[i] is still set.
  - eret and ack in the same cycle: eret clears first, then ack sets.
  - en_we and a state change in the same cycle: the enable update applies to the next cycle's arbitration.
- Arithmetic: vector computed modulo 2^ADDR_W.
- Mid-operation reset: all state clears asynchronously; int_req deasserts immediately; in-flight pending edges are lost.

Optional Feature:
- Macro: INT_NEST_EN.
- Defined: nested preemption per the eligibility rule above. A higher-priority source is granted while a lower ISR is in service, and in_service can hold multiple bits.
- Undefined:
  - Eligibility additionally requires in_service==0, so no nesting.
  - in_service is at most one-hot.
  - int_eret simply clears in_service.

Test Plan:
- Reset, pulse irq_in=3'b001 for 10 cycles -> pending=001 after 3 cycles; int_req=1 with int_id=0, int_vec=12'h100 one cycle later; ack -> pending=000, in_service=001, int_req=0 next cycle.
- irq_in=3'b101 same cycle -> first grant int_id=2, int_vec=12'h120; after ack, eret -> second grant int_id=0, int_vec=12'h100 (non-nest); with INT_NEST_EN, source 0 waits until in_service[2] clears.
- INT_NEST_EN: source 0 in service, pulse source 1 -> int_req with int_id=1, int_vec=12'h110; ack -> in_service=011; eret -> 001; eret -> 000.
- en_wdata=3'b110 then pulse source 0 -> pending=001, int_req stays 0; write en_wdata=3'b111 -> request raised 2 cycles after the write.
- In REQ for source 0, pulse source 2 -> int_id stays 0 until ack; then source 2 granted (INT_NEST_EN) or held until eret (without it).
- Edge on source 1 coincident with ack of 1 -> pending=010 and in_service=010 afterwards; assert rst=0 mid-REQ -> int_req=0 immediately, all outputs at reset values.
